// File: rtl/vslc_scan_sequencer.sv
// Scan-cycle controller: periodic scan tick, input latch, byte-wise program
// fetch over a req/ack port, executor handshake and output commit.
module vslc_scan_sequencer #(
    parameter int         ADDR_W      = 8,
    parameter int         PROG_LEN    = 16,
    parameter int         SCAN_PERIOD = 1024,
    parameter int         FETCH_TMO   = 255,
    parameter logic [7:0] END_OP      = 8'hFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [7:0]        i_in_pins,
    output logic [7:0]        o_in_latched,
    output logic              o_fetch_req,
    output logic [ADDR_W-1:0] o_fetch_addr,
    input  logic              i_fetch_ack,
    input  logic [7:0]        i_fetch_data,
    output logic              o_instr_valid,
    output logic [7:0]        o_instr,
    input  logic              i_exec_busy,
    output logic              o_out_commit,
    output logic              o_addr_strobe,
    output logic              o_scan_cycle_clk,
    output logic              o_overrun,
    output logic              o_fault
);
    localparam int PER_W = $clog2(SCAN_PERIOD);
    localparam int TMO_W = $clog2(FETCH_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_FETCH,
        S_EXEC,
        S_COMMIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PER_W-1:0]  r_per;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_in_latched;
    logic [7:0]        r_instr;
    logic              r_instr_valid;
    logic              r_strobe;
    logic              r_fault;
    logic              r_overrun;

    logic w_tick;
    logic w_last;
    logic w_do_latch;
    logic w_enter_fetch;
    logic w_take_ack;
    logic w_pc_inc;
    logic w_set_fault;

    assign w_tick = i_en && (r_per == '0);
    assign w_last = (r_instr == END_OP) || (r_pc == ADDR_W'(PROG_LEN - 1));

    // Free-running scan period; disabling the core parks it at 0 so that
    // re-enabling starts a scan straight away.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_per <= '0;
        end else if (!i_en || r_per == PER_W'(SCAN_PERIOD - 1)) begin
            r_per <= '0;
        end else begin
            r_per <= r_per + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_do_latch    = 1'b0;
        w_enter_fetch = 1'b0;
        w_take_ack    = 1'b0;
        w_pc_inc      = 1'b0;
        w_set_fault   = 1'b0;
        if (!i_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick && !r_fault) w_state_nxt = S_LATCH;
                end
                S_LATCH: begin
                    w_do_latch    = 1'b1;
                    w_enter_fetch = 1'b1;
                    w_state_nxt   = S_FETCH;
                end
                S_FETCH: begin
                    // An ack landing on the last allowed cycle still counts.
                    if (i_fetch_ack) begin
                        w_take_ack  = 1'b1;
                        w_state_nxt = S_EXEC;
                    end else if (r_tmo == TMO_W'(1)) begin
                        w_set_fault = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_EXEC: begin
                    // Executor cannot raise busy until it has seen instr_valid.
                    if (!r_instr_valid && !i_exec_busy) begin
                        if (w_last) begin
                            w_state_nxt = S_COMMIT;
                        end else begin
                            w_pc_inc      = 1'b1;
                            w_enter_fetch = 1'b1;
                            w_state_nxt   = S_FETCH;
                        end
                    end
                end
                S_COMMIT: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= '0;
            r_tmo         <= '0;
            r_in_latched  <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_strobe      <= 1'b0;
            r_fault       <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_instr_valid <= w_take_ack;
            r_strobe      <= w_enter_fetch;
            if (w_take_ack) r_instr <= i_fetch_data;
            if (w_do_latch) r_in_latched <= i_in_pins;

            if (!i_en || w_do_latch) begin
                r_pc <= '0;
            end else if (w_pc_inc) begin
                r_pc <= r_pc + 1'b1;
            end

            if (w_enter_fetch) begin
                r_tmo <= TMO_W'(FETCH_TMO);
            end else if (r_state == S_FETCH && r_tmo != '0) begin
                r_tmo <= r_tmo - 1'b1;
            end

            if (!i_en) begin
                r_fault <= 1'b0;
            end else if (w_set_fault) begin
                r_fault <= 1'b1;
            end

            // A tick that lands inside a scan is dropped, only flagged.
            if (!i_en) begin
                r_overrun <= 1'b0;
            end else if (w_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_in_latched     = r_in_latched;
    assign o_fetch_req      = (r_state == S_FETCH);
    assign o_fetch_addr     = r_pc;
    assign o_instr_valid    = r_instr_valid;
    assign o_instr          = r_instr;
    assign o_out_commit     = (r_state == S_COMMIT);
    assign o_addr_strobe    = r_strobe;
    assign o_scan_cycle_clk = (r_state != S_IDLE);
    assign o_overrun        = r_overrun;
    assign o_fault          = r_fault;

endmodule
